// File: rtl/nios_pio_pkg.sv
// Shared definitions for the Nios PIO-style slaves: register word addresses
// and the edge-type selector used by the edge-capture logic.
package nios_pio_pkg;

  typedef enum int unsigned {
    EDGE_RISING  = 0,
    EDGE_FALLING = 1,
    EDGE_ANY     = 2
  } edge_type_e;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  localparam int unsigned PIO_DATA_W = 32;

endpackage

// File: rtl/nios_pio_edge_detect.sv
// Input sampling chain and per-bit edge detector for the hw-to-sw port.
// HW_TO_SW_SYNC_EN adds a metastability flop ahead of the sampled value.
module nios_pio_edge_detect
  import nios_pio_pkg::*;
#(
  parameter int unsigned WIDTH     = 3,
  parameter edge_type_e  EDGE_TYPE = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] edge_pulse
);

  logic [WIDTH-1:0] samp_q, samp_d;
  logic [WIDTH-1:0] samp_dly_q, samp_dly_d;

`ifdef HW_TO_SW_SYNC_EN
  logic [WIDTH-1:0] meta_q, meta_d;

  always_comb begin
    meta_d = in_port;
    samp_d = meta_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
    end else begin
      meta_q <= meta_d;
    end
  end
`else
  always_comb begin
    samp_d = in_port;
  end
`endif

  always_comb begin
    samp_dly_d = samp_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp_q     <= '0;
      samp_dly_q <= '0;
    end else begin
      samp_q     <= samp_d;
      samp_dly_q <= samp_dly_d;
    end
  end

  always_comb begin
    s = samp_q;
    case (EDGE_TYPE)
      EDGE_FALLING: edge_pulse = ~samp_q & samp_dly_q;
      EDGE_ANY:     edge_pulse = samp_q ^ samp_dly_q;
      default:      edge_pulse = samp_q & ~samp_dly_q;
    endcase
  end

endmodule

// File: rtl/nios_system_hw_to_sw.sv
// Avalon-MM input port: DATA / IRQMASK / EDGECAP register window with a
// maskable level irq. Build option: HW_TO_SW_SYNC_EN (input synchronizer).
module nios_system_hw_to_sw
  import nios_pio_pkg::*;
#(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  if (WIDTH < 1 || WIDTH > PIO_DATA_W) begin : g_bad_width
    $error("nios_system_hw_to_sw: WIDTH must be 1..32");
  end
  if (EDGE_TYPE > 2) begin : g_bad_edge
    $error("nios_system_hw_to_sw: EDGE_TYPE must be 0..2");
  end

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] edge_pulse;

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] edgecap_clr;

  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;

  nios_pio_edge_detect #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (edge_type_e'(EDGE_TYPE))
  ) u_edge_detect (
    .clk        (clk),
    .reset      (reset),
    .in_port    (in_port),
    .s          (s),
    .edge_pulse (edge_pulse)
  );

  if (WIDTH < PIO_DATA_W) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^writedata[PIO_DATA_W-1:WIDTH];
  end

  always_comb begin
    wr_en   = chipselect && !write_n;
    wr_data = writedata[WIDTH-1:0];

    irqmask_d = irqmask_q;
    if (wr_en && (address == PIO_ADDR_IRQMASK)) begin
      irqmask_d = wr_data;
    end

    edgecap_clr = '0;
    if (wr_en && (address == PIO_ADDR_EDGECAP)) begin
      edgecap_clr = wr_data;
    end
    // Set is OR'd after the clear so a coincident edge keeps its flag.
    edgecap_d = (edgecap_q & ~edgecap_clr) | edge_pulse;

    readdata_d = '0;
    case (address)
      PIO_ADDR_DATA:    readdata_d[WIDTH-1:0] = s;
      PIO_ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
      PIO_ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
      default:          readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  always_comb begin
    readdata = readdata_q;
    irq      = |(edgecap_q & irqmask_q);
  end

endmodule

// File: tb/tb_nios_system_hw_to_sw.sv
// Directed bench for nios_system_hw_to_sw: three instances (rising, falling,
// any) share one bus and input so every stimulus exercises all edge types.
module tb_nios_system_hw_to_sw;

`ifdef HW_TO_SW_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [2:0]  in_port;
  logic [31:0] rd_r, rd_f, rd_a;
  logic        irq_r, irq_f, irq_a;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nios_system_hw_to_sw #(.WIDTH(3), .EDGE_TYPE(0)) dut_r (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_r),
    .in_port(in_port), .irq(irq_r));

  nios_system_hw_to_sw #(.WIDTH(3), .EDGE_TYPE(1)) dut_f (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_f),
    .in_port(in_port), .irq(irq_f));

  nios_system_hw_to_sw #(.WIDTH(3), .EDGE_TYPE(2)) dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a),
    .in_port(in_port), .irq(irq_a));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd(input logic [1:0] a);
    address    = a;
    chipselect = 1'b0;
    write_n    = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 3'b000;
    cyc(3);
    reset = 1'b0;
    cyc(2);

    // 1: reset state, then DATA latency
    rd(2'd0); chk("rst_data", rd_r, 32'h0);
    rd(2'd1); chk("rst_rsvd", rd_r, 32'h0);
    rd(2'd2); chk("rst_mask", rd_r, 32'h0);
    rd(2'd3); chk("rst_ecap", rd_r, 32'h0);
    chk("rst_irq", {29'd0, irq_r, irq_f, irq_a}, 32'h0);

    address = 2'd0;
    in_port = 3'b101;
    cyc(LAT); chk("data_early", rd_r, 32'h0);
    cyc(1);   chk("data_lat", rd_r, 32'h5);
    rd(2'd3);
    chk("t1_ecap_r", rd_r, 32'h5);
    chk("t1_ecap_f", rd_f, 32'h0);
    chk("t1_ecap_a", rd_a, 32'h5);
    chk("t1_irq_nomask", {29'd0, irq_r, irq_f, irq_a}, 32'h0);
    wr(2'd3, 32'h7);
    rd(2'd3); chk("t1_clr", rd_r, 32'h0);

    // 2: masked rising edge on bit 1, then W1C
    wr(2'd2, 32'h2);
    in_port = 3'b111;
    cyc(LAT + 1);
    chk("t2_irq_r", {31'd0, irq_r}, 32'h1);
    chk("t2_irq_f", {31'd0, irq_f}, 32'h0);
    chk("t2_irq_a", {31'd0, irq_a}, 32'h1);
    rd(2'd3); chk("t2_ecap", rd_r, 32'h2);
    wr(2'd3, 32'h2);
    chk("t2_irq_clr", {31'd0, irq_r}, 32'h0);
    rd(2'd3); chk("t2_ecap_clr", rd_r, 32'h0);

    // 3: unmasked capture, mask enabled afterwards
    wr(2'd2, 32'h0);
    in_port = 3'b000;
    cyc(LAT + 1);
    rd(2'd3);
    chk("t3_fall_f", rd_f, 32'h7);
    chk("t3_fall_r", rd_r, 32'h0);
    wr(2'd3, 32'h7);
    in_port = 3'b001;
    cyc(LAT + 1);
    chk("t3_irq_masked", {31'd0, irq_r}, 32'h0);
    rd(2'd3); chk("t3_ecap", rd_r, 32'h1);
    wr(2'd2, 32'h1);
    chk("t3_irq_r", {31'd0, irq_r}, 32'h1);
    chk("t3_irq_f", {31'd0, irq_f}, 32'h0);
    rd(2'd2); chk("t3_mask", rd_r, 32'h1);

    // 4: W1C of bit 2 coincident with its rising edge
    in_port = 3'b101;
    cyc(LAT);
    wr(2'd3, 32'h4);
    rd(2'd3);
    chk("t4_setwins_r", rd_r, 32'h5);
    chk("t4_setwins_a", rd_a, 32'h5);
    wr(2'd3, 32'h4);
    rd(2'd3); chk("t4_w1c_bit", rd_r, 32'h1);

    // 5: any-edge catches a fall; falling ignores a rise
    wr(2'd3, 32'h7);
    in_port = 3'b001;
    cyc(LAT + 1);
    rd(2'd3);
    chk("t5_any_fall", rd_a, 32'h4);
    chk("t5_fall_fall", rd_f, 32'h4);
    chk("t5_rise_fall", rd_r, 32'h0);
    wr(2'd3, 32'h7);
    in_port = 3'b101;
    cyc(LAT + 1);
    rd(2'd3);
    chk("t5_fall_rise", rd_f, 32'h0);
    chk("t5_rise_rise", rd_r, 32'h4);
    chk("t5_any_rise", rd_a, 32'h4);

    // 6: writes to DATA/reserved ignored; async reset clears everything
    wr(2'd2, 32'h7);
    wr(2'd3, 32'h7);
    in_port = 3'b000;
    cyc(LAT + 1);
    wr(2'd3, 32'h7);
    in_port = 3'b111;
    cyc(LAT + 1);
    wr(2'd0, 32'h7); wr(2'd0, 32'h0);
    wr(2'd1, 32'h7); wr(2'd1, 32'h0);
    rd(2'd3); chk("t6_ecap", rd_r, 32'h7);
    rd(2'd2); chk("t6_mask", rd_r, 32'h7);
    rd(2'd1); chk("t6_rsvd", rd_r, 32'h0);
    rd(2'd0); chk("t6_data", rd_r, 32'h7);
    chk("t6_irq", {31'd0, irq_r}, 32'h1);
    reset = 1'b1;
    #1;
    chk("t6_rst_irq", {29'd0, irq_r, irq_f, irq_a}, 32'h0);
    chk("t6_rst_rd", rd_r | rd_f | rd_a, 32'h0);
    cyc(2);
    reset = 1'b0;
    rd(2'd2); chk("t6_rst_mask", rd_r, 32'h0);
    cyc(LAT);
    rd(2'd3); chk("t6_post_edge", rd_r, 32'h7);
    chk("t6_post_irq", {31'd0, irq_r}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
